prog_loader: RTL and testbench

- Byte-stream boot loader between a host/debug byte channel and the core's instruction memory and register file.
- Replaces hierarchical preloading of imem and regfile with a synthesizable, framed load path.
- Holds the core in reset until a RUN command arrives.
- Parametrised in data width, imem depth and register count. Adds length framing, checksum and error reporting.

---
 rtl/prog_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Framed byte-stream boot loader. Parses CMD/LEN/DATA/CSUM
//                frames from a host byte channel, writes words into the
//                instruction memory or register file, and holds the core in
//                reset until a RUN command arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int  XLEN       = 32,
    parameter int  IMEM_BYTES = 1024,
    parameter int  NREGS      = 32,
    localparam int BYTES      = XLEN / 8,
    localparam int IMEM_AW    = $clog2(IMEM_BYTES),
    localparam int RF_AW      = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic [2:0]         err
);

    // Width of the byte-within-word counter (at least one bit)
    localparam int c_bcw = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [7:0] c_cmd_imem = 8'h01;
    localparam logic [7:0] c_cmd_regs = 8'h02;
    localparam logic [7:0] c_cmd_run  = 8'h03;
    localparam logic [7:0] c_cmd_halt = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RUN  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_in_ready;
    logic               r_tgt_regs;     // 0: imem target, 1: regfile target
    logic [15:0]        r_len;
    logic [15:0]        r_wcnt;         // words completed in this frame
    logic [c_bcw-1:0]   r_bcnt;         // bytes accepted in the current word
    logic [XLEN-1:0]    r_word;
    logic [7:0]         r_sum;
    logic [2:0]         r_err;
    logic               r_core_rst;

    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [XLEN-1:0]    r_imem_wdata;
    logic               r_rf_we;
    logic [RF_AW-1:0]   r_rf_waddr;
    logic [XLEN-1:0]    r_rf_wdata;

    logic               w_accept;
    logic               w_last_byte;
    logic               w_last_word;
    logic [15:0]        w_len_full;
    logic [31:0]        w_byte_off;
    logic [XLEN-1:0]    w_word_full;

    assign w_accept    = in_valid & r_in_ready;
    assign w_last_byte = (r_bcnt == c_bcw'(BYTES - 1));
    assign w_last_word = (r_wcnt == (r_len - 16'd1));
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_byte_off  = {16'd0, r_wcnt} * 32'(BYTES);

    // Current word with the incoming byte merged into its little-endian lane
    always_comb begin
        w_word_full = r_word;
        for (int i = 0; i < BYTES; i++) begin
            if (r_bcnt == c_bcw'(i)) begin
                w_word_full[i*8 +: 8] = in_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; transitions only on an accepted byte
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_data == c_cmd_imem || in_data == c_cmd_regs) begin
                        w_next = S_LEN0;
                    end else if (in_data == c_cmd_run) begin
                        w_next = S_RUN;
                    end
                end
            end
            S_LEN0: if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    w_next = (w_len_full == 16'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word) begin
                    w_next = S_CSUM;
                end
            end
            S_CSUM: if (w_accept) w_next = S_IDLE;
            S_RUN: begin
                if (w_accept && in_data == c_cmd_halt) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame datapath: length capture, word assembly, checksum, write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready   <= 1'b0;
            r_tgt_regs   <= 1'b0;
            r_len        <= '0;
            r_wcnt       <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_sum        <= '0;
            r_err        <= '0;
            r_core_rst   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
            r_rf_we    <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (in_data == c_cmd_imem || in_data == c_cmd_regs) begin
                            r_tgt_regs <= (in_data == c_cmd_regs);
                            r_sum      <= '0;
                            r_bcnt     <= '0;
                            r_wcnt     <= '0;
                            r_word     <= '0;
                        end else if (in_data == c_cmd_run) begin
                            r_core_rst <= 1'b0;
                        end else if (in_data != c_cmd_halt) begin
                            r_err[0] <= 1'b1;
                        end
                    end
                    S_LEN0: r_len[7:0]  <= in_data;
                    S_LEN1: r_len[15:8] <= in_data;
                    S_DATA: begin
                        r_word <= w_word_full;
                        r_sum  <= r_sum + in_data;
                        if (w_last_byte) begin
                            r_bcnt <= '0;
                            r_wcnt <= r_wcnt + 16'd1;
                            if (!r_tgt_regs) begin
                                // No wrap: out-of-range words are dropped and flagged
                                if (w_byte_off < 32'(IMEM_BYTES)) begin
                                    r_imem_we    <= 1'b1;
                                    r_imem_addr  <= w_byte_off[IMEM_AW-1:0];
                                    r_imem_wdata <= w_word_full;
                                end else begin
                                    r_err[1] <= 1'b1;
                                end
                            end else begin
                                // x0 is hardwired: its word is consumed silently
                                if (r_wcnt == 16'd0) begin
                                    r_rf_we <= 1'b0;
                                end else if ({16'd0, r_wcnt} < 32'(NREGS)) begin
                                    r_rf_we    <= 1'b1;
                                    r_rf_waddr <= r_wcnt[RF_AW-1:0];
                                    r_rf_wdata <= w_word_full;
                                end else begin
                                    r_err[1] <= 1'b1;
                                end
                            end
                        end else begin
                            r_bcnt <= r_bcnt + c_bcw'(1);
                        end
                    end
                    S_CSUM: begin
                        if (in_data != r_sum) begin
                            r_err[2] <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (in_data == c_cmd_halt) begin
                            r_core_rst <= 1'b1;
                        end
                    end
                    default: begin
                        r_core_rst <= r_core_rst;
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign core_rst   = r_core_rst;
    assign err        = r_err;
    assign busy       = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Frames are built from
//                word lists; expected writes, strobe cycles and error flags
//                come from a frame-level model of the loader protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int XLEN       = 32;
    localparam int BYTES      = 4;
    localparam int IMEM_BYTES = 64;
    localparam int NREGS      = 32;
    localparam int IMEM_AW    = 6;
    localparam int RF_AW      = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [XLEN-1:0]    imem_wdata;
    logic               rf_we;
    logic [RF_AW-1:0]   rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               core_rst;
    logic               busy;
    logic [2:0]         err;

    prog_loader #(.XLEN(XLEN), .IMEM_BYTES(IMEM_BYTES), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .core_rst(core_rst), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_im[$], got_im[$], exp_rf[$], got_rf[$];
    logic [31:0] wq[$];
    logic [2:0]  m_err;
    bit          m_run;
    bit          stall_en;
    int          checks = 0;
    int          errors = 0;

    // Record every write strobe with the cycle it was seen
    always @(negedge clk) begin
        if (imem_we) got_im.push_back('{cyc, 32'(imem_addr), imem_wdata});
        if (rf_we)   got_rf.push_back('{cyc, 32'(rf_waddr), rf_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte; stamp is the cycle index of the accepting edge minus one
    task automatic send_byte(input logic [7:0] b, output int stamp);
        int budget;
        @(negedge clk);
        if (stall_en && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        budget = 0;
        while (!in_ready && budget < 20) begin
            in_valid = 1'b0;
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        stamp    = cyc;
        @(posedge clk);
    endtask

    task automatic release_bus;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send one CMD/LEN/DATA/CSUM frame from wq and predict its effects
    task automatic send_frame(input logic [7:0] cmd, input bit bad_csum);
        logic [7:0]  sum;
        logic [7:0]  b;
        int          st;
        int          n;
        n   = wq.size();
        sum = 8'd0;
        send_byte(cmd, st);
        send_byte(8'(n), st);
        send_byte(8'(n >> 8), st);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < BYTES; j++) begin
                b   = 8'(wq[k] >> (8 * j));
                sum = sum + b;
                send_byte(b, st);
            end
            if (cmd == 8'h01) begin
                if (k * BYTES < IMEM_BYTES) exp_im.push_back('{st + 1, 32'(k * BYTES), wq[k]});
                else m_err[1] = 1'b1;
            end else if (k != 0) begin
                if (k < NREGS) exp_rf.push_back('{st + 1, 32'(k), wq[k]});
                else m_err[1] = 1'b1;
            end
        end
        if (bad_csum) begin
            sum      = sum ^ 8'($urandom_range(1, 255));
            m_err[2] = 1'b1;
        end
        send_byte(sum, st);
        release_bus();
    endtask

    task automatic compare_all(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_imem_n"}, got_im.size(), exp_im.size());
        for (int i = 0; i < exp_im.size() && i < got_im.size(); i++) begin
            check({tag, "_imem_cyc"},  got_im[i].c, exp_im[i].c);
            check({tag, "_imem_addr"}, got_im[i].a, exp_im[i].a);
            check({tag, "_imem_data"}, got_im[i].d, exp_im[i].d);
        end
        check({tag, "_rf_n"}, got_rf.size(), exp_rf.size());
        for (int i = 0; i < exp_rf.size() && i < got_rf.size(); i++) begin
            check({tag, "_rf_cyc"},  got_rf[i].c, exp_rf[i].c);
            check({tag, "_rf_addr"}, got_rf[i].a, exp_rf[i].a);
            check({tag, "_rf_data"}, got_rf[i].d, exp_rf[i].d);
        end
        check({tag, "_err"},      err, m_err);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_core_rst"}, core_rst, !m_run);
        check({tag, "_in_ready"}, in_ready, 1);
        got_im.delete(); exp_im.delete(); got_rf.delete(); exp_rf.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_in_ready_low", in_ready, 0);
        rst   = 1'b0;
        m_err = 3'b000;
        m_run = 1'b0;
        @(negedge clk);
        check("rst_in_ready_high", in_ready, 1);
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        got_im.delete(); exp_im.delete(); got_rf.delete(); exp_rf.delete();
    endtask

    task automatic do_run;
        int st;
        send_byte(8'h03, st);
        @(negedge clk);
        in_valid = 1'b0;
        check("run_core_rst_low", core_rst, 0);
        check("run_busy", busy, 0);
        m_run = 1'b1;
    endtask

    task automatic do_halt;
        int st;
        send_byte(8'h04, st);
        @(negedge clk);
        in_valid = 1'b0;
        check("halt_core_rst_high", core_rst, 1);
        check("halt_busy", busy, 0);
        m_run = 1'b0;
    endtask

    // Stray byte: flags a command error only in IDLE and only for unknown codes
    task automatic send_junk(input logic [7:0] b);
        int st;
        send_byte(b, st);
        release_bus();
        if (!m_run && (b == 8'h00 || b > 8'h04)) m_err[0] = 1'b1;
    endtask

    task automatic fill_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int st;
        int r;
        int n;
        logic [7:0] b;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        stall_en = 1'b0;
        m_err    = 3'b000;
        m_run    = 1'b0;
        repeat (3) @(negedge clk);
        check("por_in_ready", in_ready, 0);
        check("por_core_rst", core_rst, 1);
        check("por_imem_we", imem_we, 0);
        check("por_rf_we", rf_we, 0);
        check("por_err", err, 0);
        check("por_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("por_in_ready_after", in_ready, 1);

        // Single-word imem load: 01 01 00 33 84 20 00 D7
        wq = '{32'h00208433};
        send_frame(8'h01, 1'b0);
        check("t1_data_literal", (got_im.size() > 0) ? got_im[0].d : 32'h0, 32'h00208433);
        compare_all("t1");

        // Two-word imem load with stalls, then RUN
        stall_en = 1'b1;
        wq = '{32'h00007033, 32'h00100093};
        send_frame(8'h01, 1'b0);
        compare_all("t2");
        do_run();
        compare_all("t2run");
        do_halt();

        // Register load: index 0 swallowed
        wq = '{32'h00000011, 32'hFFFFFFF0, 32'h00000002};
        send_frame(8'h02, 1'b0);
        compare_all("t3");

        // Bad checksum still writes
        do_reset();
        wq = '{32'hDEADBEEF, 32'h12345678};
        send_frame(8'h01, 1'b1);
        compare_all("t4");

        // IMEM overflow: word 16 lands at IMEM_BYTES and is dropped
        do_reset();
        fill_words(17);
        send_frame(8'h01, 1'b0);
        compare_all("t5");

        // Bad command, RUN, ignored byte, HALT
        do_reset();
        send_junk(8'h7F);
        compare_all("t6a");
        do_run();
        send_junk(8'h55);
        compare_all("t6b");
        do_halt();
        compare_all("t6c");

        // Reset in the middle of a word
        do_reset();
        send_byte(8'h01, st); send_byte(8'h01, st); send_byte(8'h00, st);
        send_byte(8'hAA, st); send_byte(8'hBB, st);
        do_reset();
        repeat (4) @(negedge clk);
        check("t7_no_partial_write", got_im.size(), 0);
        wq = '{32'hCAFEF00D};
        send_frame(8'h01, 1'b0);
        compare_all("t7");

        // Randomized mix of frames and control bytes
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                n = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 5);
                fill_words(n);
                send_frame(8'h01, $urandom_range(0, 4) == 0);
            end else if (r <= 6) begin
                n = ($urandom_range(0, 7) == 0) ? 33 : $urandom_range(0, 5);
                fill_words(n);
                send_frame(8'h02, $urandom_range(0, 4) == 0);
            end else if (r == 7) begin
                b = 8'($urandom_range(0, 255));
                if (b >= 8'h01 && b <= 8'h03) b = 8'hA5;
                send_junk(b);
            end else if (r == 8) begin
                do_run();
                repeat ($urandom_range(0, 3)) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h04) b = 8'h05;
                    send_junk(b);
                end
                do_halt();
            end else begin
                do_reset();
            end
            compare_all("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
